// File: rtl/and5_qualifier.sv
// and5_qualifier: debounces the single-bit output of the 5-input AND gate into a
// qualifier that sets after HOLD_CYCLES consecutive high samples and clears after
// REL_CYCLES consecutive low samples. Qualified rises are counted in a saturating,
// host-clearable counter.
// Optional feature macro: AND5_QUAL_RUNLEN_EN -- when defined, last_run reports the
// length in cycles of the most recent completed qualified period; when undefined the
// last_run port is tied to zero and no run counter is built.
module and5_qualifier #(
    parameter int HOLD_CYCLES = 4,
    parameter int REL_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             and_in,
    input  logic             clear,
    output logic             qual_out,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             cnt_sat,
    output logic [CNT_W-1:0] last_run
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMING,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RelLast  = CNT_W'(REL_CYCLES - 1);

    state_t           state_q, state_d;
    logic             in_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] eventCnt_q, eventCnt_d;
    logic             cntSat_q, cntSat_d;
    logic             risePulse_q;
    logic             riseEvent;
    logic             qualified;

    assign qualified  = (state_q == ST_ACTIVE) || (state_q == ST_RELEASE);
    assign qual_out   = qualified;
    assign rise_pulse = risePulse_q;
    assign event_cnt  = eventCnt_q;
    assign cnt_sat    = cntSat_q;

    // Next-state logic: arm/release counters and flag entry into ACTIVE as a new event
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        rcnt_d    = rcnt_q;
        riseEvent = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                rcnt_d = '0;
                if (in_q) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d   = ST_ACTIVE;
                        riseEvent = 1'b1;
                    end else begin
                        state_d = ST_ARMING;
                        hcnt_d  = CNT_W'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (!in_q) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                end else if (hcnt_q == HoldLast) begin
                    state_d   = ST_ACTIVE;
                    hcnt_d    = '0;
                    riseEvent = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!in_q) begin
                    if (REL_CYCLES == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                        rcnt_d  = CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (in_q) begin
                    state_d = ST_ACTIVE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RelLast) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
                rcnt_d  = '0;
            end
        endcase
    end

    // Event counter: clear wins over the old count but a coincident rise still counts
    always_comb begin
        eventCnt_d = eventCnt_q;
        if (clear) begin
            eventCnt_d = riseEvent ? CNT_W'(1) : '0;
        end else if (riseEvent && (eventCnt_q != CntMax)) begin
            eventCnt_d = eventCnt_q + CNT_W'(1);
        end
        cntSat_d = (eventCnt_d == CntMax);
    end

    // State, input sample and event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_q        <= 1'b0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            eventCnt_q  <= '0;
            cntSat_q    <= 1'b0;
            risePulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= and_in;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            eventCnt_q  <= eventCnt_d;
            cntSat_q    <= cntSat_d;
            risePulse_q <= riseEvent;
        end
    end

`ifdef AND5_QUAL_RUNLEN_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] lastRun_q, lastRun_d;

    // Run length: the counter already covers the final qualified cycle when IDLE is entered
    always_comb begin
        run_d     = run_q;
        lastRun_d = lastRun_q;
        if (riseEvent) begin
            run_d = CNT_W'(1);
        end else if (qualified && (run_q != CntMax)) begin
            run_d = run_q + CNT_W'(1);
        end
        if (qualified && (state_d == ST_IDLE)) begin
            lastRun_d = run_q;
        end
    end

    // Run length registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            lastRun_q <= '0;
        end else begin
            run_q     <= run_d;
            lastRun_q <= lastRun_d;
        end
    end

    assign last_run = lastRun_q;
`else
    assign last_run = '0;
`endif

endmodule
